// File: rtl/texture_store.sv
// Texture block store: byte-strobed 32-bit write port, whole-block pipelined read port,
// and a clear sequencer that zero-fills every block after reset or on request.
module texture_store #(
    parameter int                ROWS      = 16,
    parameter int                ROW_W     = 128,
    parameter int                TEX_COUNT = 128,
    parameter int                ADDR_W    = 27,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'('h2000)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_wea,
    input  logic [ADDR_W-1:0]       i_waddr,
    input  logic [31:0]             i_wdata,
    input  logic [3:0]              i_wstrb,
    input  logic                    i_clear,
    input  logic                    i_req,
    input  logic [7:0]              i_texture_idx,
    output logic                    o_ready,
    output logic                    o_valid,
    output logic [ROWS*ROW_W-1:0]   o_texture_data,
    output logic                    o_werr,
    output logic                    o_rerr
);

    localparam int BLK_W     = ROWS * ROW_W;
    localparam int WPR       = ROW_W / 32;
    localparam int BLK_BYTES = BLK_W / 8;
    localparam int IDX_W     = $clog2(TEX_COUNT);
    localparam int ROWI_W    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int LANE_W    = (WPR > 1) ? $clog2(WPR) : 1;
    localparam int BE_W      = ROW_W / 8;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t           state_q;
    logic [IDX_W:0]   cnt_q;
    logic             ready_q;
    logic             werr_q;

    logic [ADDR_W-1:0] wOff, wBlk, wWord, wRowFull, wLaneFull;
    logic              wInRange;
    logic [ROWI_W-1:0] wRow;
    logic [LANE_W-1:0] wLane;
    logic [IDX_W-1:0]  wIdx;

    assign wOff      = i_waddr - BASE_ADDR;
    assign wBlk      = wOff / ADDR_W'(BLK_BYTES);
    assign wWord     = (wOff % ADDR_W'(BLK_BYTES)) >> 2;
    assign wRowFull  = wWord / ADDR_W'(WPR);
    assign wLaneFull = wWord % ADDR_W'(WPR);
    assign wInRange  = (i_waddr >= BASE_ADDR) && (wBlk < ADDR_W'(TEX_COUNT));
    assign wRow      = ROWI_W'(wRowFull);
    assign wLane     = LANE_W'(wLaneFull);
    assign wIdx      = IDX_W'(wBlk);

    // Port A is shared: the clear sequencer owns it while clearing, user writes otherwise.
    logic              wrAccept;
    logic              clearing;
    logic [IDX_W-1:0]  aAddr;
    logic [BE_W-1:0]   aBe;
    logic [ROW_W-1:0]  aData;

    assign wrAccept = i_wea && ready_q && wInRange;
    assign clearing = (state_q == CLEAR) && !cnt_q[IDX_W];
    assign aAddr    = clearing ? cnt_q[IDX_W-1:0] : wIdx;
    assign aBe      = clearing ? '1 : (BE_W'(i_wstrb) << {wLane, 2'b00});
    assign aData    = clearing ? '0 : {WPR{i_wdata}};

    logic              rdAccept;
    logic              rdOor;
    logic [IDX_W-1:0]  rdIdx;
    logic [BLK_W-1:0]  ramBlk;

    assign rdAccept = i_req && ready_q;
    assign rdOor    = (i_texture_idx >> IDX_W) != 8'd0;
    assign rdIdx    = IDX_W'(i_texture_idx);

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        logic [ROW_W-1:0] mem [TEX_COUNT];
        logic [ROW_W-1:0] rd_q;
        logic             we;

        assign we = clearing || (wrAccept && (wRow == ROWI_W'(r)));

        // Non-blocking read on port B gives read-first behaviour against a same-edge write.
        always_ff @(posedge clk) begin
            for (int b = 0; b < BE_W; b++) begin
                if (we && aBe[b]) begin
                    mem[aAddr][8*b +: 8] <= aData[8*b +: 8];
                end
            end
            if (rdAccept) begin
                rd_q <= mem[rdIdx];
            end
        end

        assign ramBlk[ROW_W*r +: ROW_W] = rd_q;
    end

    logic             v1_q, oor1_q, v2_q, oor2_q, valid_q, rerr_q;
    logic [BLK_W-1:0] blk2_q;
    logic [BLK_W-1:0] data_q;

    always_ff @(posedge clk) begin
        blk2_q <= ramBlk;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q    <= 1'b0;
            oor1_q  <= 1'b0;
            v2_q    <= 1'b0;
            oor2_q  <= 1'b0;
            valid_q <= 1'b0;
            rerr_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            v1_q    <= rdAccept;
            oor1_q  <= rdOor;
            v2_q    <= v1_q;
            oor2_q  <= oor1_q;
            valid_q <= v2_q;
            rerr_q  <= v2_q && oor2_q;
            if (v2_q) begin
                data_q <= oor2_q ? '0 : blk2_q;
            end
        end
    end

    // cnt runs one past the last block so the exit edge is a cycle of its own.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            werr_q  <= 1'b0;
        end else begin
            case (state_q)
                CLEAR: begin
                    if (cnt_q[IDX_W]) begin
                        state_q <= RUN;
                        ready_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RUN: begin
                    if (i_wea && !wInRange) begin
                        werr_q <= 1'b1;
                    end
                    if (i_clear) begin
                        state_q <= CLEAR;
                        cnt_q   <= '0;
                        ready_q <= 1'b0;
                        werr_q  <= 1'b0;
                    end
                end
                default: state_q <= CLEAR;
            endcase
        end
    end

    assign o_ready        = ready_q;
    assign o_valid        = valid_q;
    assign o_texture_data = data_q;
    assign o_werr         = werr_q;
    assign o_rerr         = rerr_q;

endmodule

// File: tb/tb_texture_store.sv
// Directed self-checking bench for texture_store with default geometry.
module tb_texture_store;

    localparam int BLK_W = 2048;

    logic             clk = 1'b0;
    logic             rst;
    logic             i_wea;
    logic [26:0]      i_waddr;
    logic [31:0]      i_wdata;
    logic [3:0]       i_wstrb;
    logic             i_clear;
    logic             i_req;
    logic [7:0]       i_texture_idx;
    logic             o_ready;
    logic             o_valid;
    logic [BLK_W-1:0] o_texture_data;
    logic             o_werr;
    logic             o_rerr;

    int checks = 0;
    int errors = 0;

    texture_store dut (
        .clk            (clk),
        .rst            (rst),
        .i_wea          (i_wea),
        .i_waddr        (i_waddr),
        .i_wdata        (i_wdata),
        .i_wstrb        (i_wstrb),
        .i_clear        (i_clear),
        .i_req          (i_req),
        .i_texture_idx  (i_texture_idx),
        .o_ready        (o_ready),
        .o_valid        (o_valid),
        .o_texture_data (o_texture_data),
        .o_werr         (o_werr),
        .o_rerr         (o_rerr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int firstDiff(input logic [BLK_W-1:0] a, input logic [BLK_W-1:0] b);
        for (int w = 0; w < BLK_W / 32; w++) begin
            if (a[32*w +: 32] !== b[32*w +: 32]) return w;
        end
        return 0;
    endfunction

    task automatic writeWord(input logic [26:0] addr, input logic [31:0] data, input logic [3:0] strb);
        i_wea   = 1'b1;
        i_waddr = addr;
        i_wdata = data;
        i_wstrb = strb;
        tick();
        i_wea   = 1'b0;
    endtask

    // Issues one request and waits (bounded) for its valid; lat counts edges after acceptance.
    task automatic readBlock(input logic [7:0] idx, output logic [BLK_W-1:0] data,
                             output int lat, output logic rerr);
        i_req         = 1'b1;
        i_texture_idx = idx;
        tick();
        i_req = 1'b0;
        lat   = 0;
        while (o_valid !== 1'b1 && lat < 10) begin
            tick();
            lat++;
        end
        data = o_texture_data;
        rerr = o_rerr;
    endtask

    task automatic test_reset();
        int lowCnt, lat, w;
        logic [BLK_W-1:0] d, exp;
        logic re;
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (o_ready !== 1'b0 || o_valid !== 1'b0 || o_werr !== 1'b0 || o_rerr !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags: got ready=%b valid=%b werr=%b rerr=%b expected all 0",
                     o_ready, o_valid, o_werr, o_rerr);
        end
        exp = '0;
        checks++;
        if (o_texture_data !== exp) begin
            errors++;
            w = firstDiff(o_texture_data, exp);
            $display("[TB] FAIL reset_data: word %0d got %h expected %h", w, o_texture_data[32*w +: 32], exp[32*w +: 32]);
        end
        rst = 1'b0;
        lowCnt = 0;
        tick();
        while (o_ready !== 1'b1 && lowCnt < 400) begin
            lowCnt++;
            tick();
        end
        checks++;
        if (lowCnt !== 128) begin
            errors++;
            $display("[TB] FAIL reset_clear_cycles: got %0d expected 128", lowCnt);
        end
        readBlock(8'd5, d, lat, re);
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("[TB] FAIL read_latency: got %0d expected 2", lat);
        end
        checks++;
        if (d !== exp || re !== 1'b0) begin
            errors++;
            w = firstDiff(d, exp);
            $display("[TB] FAIL read_idx5_zero: word %0d got %h rerr %b expected %h rerr 0", w, d[32*w +: 32], re, exp[32*w +: 32]);
        end
    endtask

    task automatic test_write_strobe();
        int lat, w;
        logic [BLK_W-1:0] d, exp;
        logic re;
        writeWord(27'h2114, 32'hDEADBEEF, 4'hF);
        readBlock(8'd1, d, lat, re);
        exp = '0;
        exp[191:160] = 32'hDEADBEEF;
        checks++;
        if (d !== exp) begin
            errors++;
            w = firstDiff(d, exp);
            $display("[TB] FAIL write_full: word %0d got %h expected %h", w, d[32*w +: 32], exp[32*w +: 32]);
        end
        writeWord(27'h2114, 32'hAABBCCDD, 4'hF);
        writeWord(27'h2114, 32'h11223344, 4'b0101);
        readBlock(8'd1, d, lat, re);
        exp[191:160] = 32'hAA22CC44;
        checks++;
        if (d !== exp) begin
            errors++;
            w = firstDiff(d, exp);
            $display("[TB] FAIL write_strobe: word %0d got %h expected %h", w, d[32*w +: 32], exp[32*w +: 32]);
        end
    endtask

    task automatic test_same_cycle();
        logic [BLK_W-1:0] expOld, expNew;
        int w;
        writeWord(27'h2200, 32'h12345678, 4'hF);
        expOld = '0;
        expOld[31:0] = 32'h12345678;
        expNew = '0;
        expNew[31:0] = 32'hCAFEF00D;
        i_wea = 1'b1; i_waddr = 27'h2200; i_wdata = 32'hCAFEF00D; i_wstrb = 4'hF;
        i_req = 1'b1; i_texture_idx = 8'd2;
        tick();
        i_wea = 1'b0;
        tick();
        i_req = 1'b0;
        checks++;
        if (o_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL early_valid: got %b expected 0", o_valid);
        end
        tick();
        checks++;
        if (o_valid !== 1'b1 || o_texture_data !== expOld) begin
            errors++;
            w = firstDiff(o_texture_data, expOld);
            $display("[TB] FAIL read_first_old: valid %b word %0d got %h expected %h", o_valid, w, o_texture_data[32*w +: 32], expOld[32*w +: 32]);
        end
        tick();
        checks++;
        if (o_valid !== 1'b1 || o_texture_data !== expNew) begin
            errors++;
            w = firstDiff(o_texture_data, expNew);
            $display("[TB] FAIL next_cycle_new: valid %b word %0d got %h expected %h", o_valid, w, o_texture_data[32*w +: 32], expNew[32*w +: 32]);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] idxs [3];
        logic [BLK_W-1:0] exps [3];
        logic rerrs [3];
        int w;
        idxs[0] = 8'd200; idxs[1] = 8'd2; idxs[2] = 8'd1;
        exps[0] = '0; exps[1] = '0; exps[2] = '0;
        exps[1][31:0] = 32'hCAFEF00D;
        exps[2][191:160] = 32'hAA22CC44;
        rerrs[0] = 1'b1; rerrs[1] = 1'b0; rerrs[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            i_req = 1'b1;
            i_texture_idx = idxs[i];
            tick();
        end
        i_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (o_valid !== 1'b1 || o_rerr !== rerrs[i] || o_texture_data !== exps[i]) begin
                errors++;
                w = firstDiff(o_texture_data, exps[i]);
                $display("[TB] FAIL b2b_%0d: valid %b rerr %b word %0d got %h expected valid 1 rerr %b data %h",
                         i, o_valid, o_rerr, w, o_texture_data[32*w +: 32], rerrs[i], exps[i][32*w +: 32]);
            end
            tick();
        end
        checks++;
        if (o_valid !== 1'b0 || o_rerr !== 1'b0 || o_texture_data !== exps[2]) begin
            errors++;
            w = firstDiff(o_texture_data, exps[2]);
            $display("[TB] FAIL hold_data: valid %b rerr %b word %0d got %h expected %h", o_valid, o_rerr, w, o_texture_data[32*w +: 32], exps[2][32*w +: 32]);
        end
    endtask

    task automatic test_errors();
        int lat, w;
        logic [BLK_W-1:0] d, exp;
        logic re;
        writeWord(27'h9FFC, 32'h600DCAFE, 4'hF);
        checks++;
        if (o_werr !== 1'b0) begin
            errors++;
            $display("[TB] FAIL werr_last_legal: got %b expected 0", o_werr);
        end
        writeWord(27'hA000, 32'h77777777, 4'hF);
        checks++;
        if (o_werr !== 1'b1) begin
            errors++;
            $display("[TB] FAIL werr_above: got %b expected 1", o_werr);
        end
        writeWord(27'h1FFC, 32'h55555555, 4'hF);
        tick();
        checks++;
        if (o_werr !== 1'b1) begin
            errors++;
            $display("[TB] FAIL werr_sticky: got %b expected 1", o_werr);
        end
        exp = '0;
        exp[2047:2016] = 32'h600DCAFE;
        readBlock(8'd127, d, lat, re);
        checks++;
        if (d !== exp) begin
            errors++;
            w = firstDiff(d, exp);
            $display("[TB] FAIL blk127_unchanged: word %0d got %h expected %h", w, d[32*w +: 32], exp[32*w +: 32]);
        end
        exp = '0;
        readBlock(8'd0, d, lat, re);
        checks++;
        if (d !== exp) begin
            errors++;
            w = firstDiff(d, exp);
            $display("[TB] FAIL blk0_unchanged: word %0d got %h expected %h", w, d[32*w +: 32], exp[32*w +: 32]);
        end
        readBlock(8'd200, d, lat, re);
        checks++;
        if (d !== exp || re !== 1'b1 || lat !== 2) begin
            errors++;
            w = firstDiff(d, exp);
            $display("[TB] FAIL read_oor: word %0d got %h rerr %b lat %0d expected %h rerr 1 lat 2", w, d[32*w +: 32], re, lat, exp[32*w +: 32]);
        end
        tick();
        checks++;
        if (o_rerr !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rerr_pulse: got %b expected 0", o_rerr);
        end
    endtask

    task automatic test_clear();
        int lowCnt, lat, w;
        logic [BLK_W-1:0] d, exp;
        logic re;
        writeWord(27'h2300, 32'h0BADF00D, 4'hF);
        i_req = 1'b1;
        i_texture_idx = 8'd3;
        tick();
        i_req = 1'b0;
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
        checks++;
        if (o_ready !== 1'b0 || o_werr !== 1'b0) begin
            errors++;
            $display("[TB] FAIL clear_start: got ready=%b werr=%b expected 0 0", o_ready, o_werr);
        end
        i_wea = 1'b1; i_waddr = 27'h1FFC; i_wdata = 32'h99999999; i_wstrb = 4'hF;
        tick();
        i_wea = 1'b0;
        exp = '0;
        exp[31:0] = 32'h0BADF00D;
        checks++;
        if (o_valid !== 1'b1 || o_texture_data !== exp) begin
            errors++;
            w = firstDiff(o_texture_data, exp);
            $display("[TB] FAIL inflight_old: valid %b word %0d got %h expected %h", o_valid, w, o_texture_data[32*w +: 32], exp[32*w +: 32]);
        end
        lowCnt = 0;
        while (o_ready !== 1'b1 && lowCnt < 400) begin
            lowCnt++;
            tick();
        end
        checks++;
        if (lowCnt !== 128) begin
            errors++;
            $display("[TB] FAIL clear_cycles: got %0d expected 128", lowCnt);
        end
        checks++;
        if (o_werr !== 1'b0) begin
            errors++;
            $display("[TB] FAIL werr_after_clear: got %b expected 0", o_werr);
        end
        exp = '0;
        readBlock(8'd3, d, lat, re);
        checks++;
        if (d !== exp) begin
            errors++;
            w = firstDiff(d, exp);
            $display("[TB] FAIL blk3_cleared: word %0d got %h expected %h", w, d[32*w +: 32], exp[32*w +: 32]);
        end
    endtask

    task automatic test_reset_abort();
        int lowCnt, sawValid, w;
        logic [BLK_W-1:0] d, exp;
        int lat;
        logic re;
        writeWord(27'h2400, 32'h44444444, 4'hF);
        i_req = 1'b1;
        i_texture_idx = 8'd4;
        tick();
        i_req = 1'b0;
        rst = 1'b1;
        sawValid = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (o_valid === 1'b1) sawValid++;
        end
        rst = 1'b0;
        checks++;
        if (sawValid !== 0) begin
            errors++;
            $display("[TB] FAIL rst_drops_read: got %0d valid cycles expected 0", sawValid);
        end
        for (int i = 0; i < 40; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        lowCnt = 0;
        tick();
        while (o_ready !== 1'b1 && lowCnt < 400) begin
            i_clear = (lowCnt == 30);
            lowCnt++;
            tick();
        end
        i_clear = 1'b0;
        checks++;
        if (lowCnt !== 128) begin
            errors++;
            $display("[TB] FAIL midclear_restart_cycles: got %0d expected 128", lowCnt);
        end
        exp = '0;
        readBlock(8'd4, d, lat, re);
        checks++;
        if (d !== exp || lat !== 2) begin
            errors++;
            w = firstDiff(d, exp);
            $display("[TB] FAIL blk4_after_reset: word %0d got %h lat %0d expected %h lat 2", w, d[32*w +: 32], lat, exp[32*w +: 32]);
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        i_wea = 1'b0; i_waddr = '0; i_wdata = '0; i_wstrb = '0;
        i_clear = 1'b0; i_req = 1'b0; i_texture_idx = '0;
        test_reset();
        test_write_strobe();
        test_same_cycle();
        test_back_to_back();
        test_errors();
        test_clear();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/texture_store.md
# texture_store

Parametrised texture block store feeding the shading pipeline: a byte-addressed 32-bit write port loads texture blocks, and a request/valid read port returns one whole block per request. It generalises the fixed 16-row texture memory in four ways: parametrised geometry, byte-strobed writes, a pipelined read handshake, and a hardware clear sequencer that zero-fills the store after reset or on demand. It sits between the system-bus write decoder and the texture sampler.

## Interface
- ROWS, 16, rows per texture block
- ROW_W, 128, bits per row; must be a multiple of 32
- TEX_COUNT, 128, number of texture blocks; power of two
- ADDR_W, 27, byte-address width of the write port
- BASE_ADDR, 27'h2000, byte address of block 0
- BLK_W, derived, ROWS*ROW_W bits; default 2048
- WPR, derived, ROW_W/32 words per row
- BLK_BYTES, derived, BLK_W/8 bytes per block
- IDX_W, derived, log2(TEX_COUNT)

Ports:
- clk  in  1  single clock; all logic is rising-edge
- rst  in  1  asynchronous, active-high reset
- i_wea  in  1  write enable
- i_waddr  in  ADDR_W  byte address, word aligned (bits [1:0] ignored)
- i_wdata  in  32  write data
- i_wstrb  in  4  byte enables; bit n covers i_wdata[8n+7:8n]
- i_clear  in  1  single-cycle pulse; starts a clear sequence
- i_req  in  1  read request
- i_texture_idx  in  8  block index; only bits [IDX_W-1:0] select the block
- o_ready  out  1  read port and write port accept traffic
- o_valid  out  1  read data valid
- o_texture_data  out  BLK_W  row r occupies [ROW_W*r+ROW_W-1 -: ROW_W]
- o_werr  out  1  sticky; set by an out-of-range write
- o_rerr  out  1  single-cycle pulse; aligned with o_valid of an out-of-range read

## Operation
- Address decode: off = i_waddr - BASE_ADDR.
  - blk = off / BLK_BYTES.
  - word = (off % BLK_BYTES) >> 2.
  - row = word / WPR.
  - lane = word % WPR.
  - A write is in range when i_waddr >= BASE_ADDR and blk < TEX_COUNT.
- Write, when i_wea && o_ready && in range: updates only the strobed bytes of (blk, row, lane). Other bytes and lanes are untouched.
- An out-of-range write is dropped and sets o_werr. o_werr clears only on rst or on the start of a clear sequence.
- Writes presented while o_ready=0 are dropped silently; o_werr is not set.
- Read, when i_req && o_ready: the request is accepted.
  - Index out of range (bits of i_texture_idx at or above IDX_W nonzero): data is all zeros and o_rerr pulses.
- Read-first semantics: a read returns the block as it stood before any write in the acceptance cycle. Writes accepted in earlier cycles are always visible.
- FSM states:
  - CLEAR: entered from reset, or from RUN on i_clear. Writes zeros to block cnt, cnt = 0..TEX_COUNT-1, one block per cycle, all rows in parallel. Exits to RUN after block TEX_COUNT-1 is written. o_ready=0 throughout.
  - RUN: o_ready=1. i_clear moves to CLEAR next cycle and resets cnt and o_werr. Any write or request in the i_clear cycle is still accepted.
- i_clear during CLEAR is ignored; the sequence is not restarted.
- Reads already in flight when CLEAR starts complete normally with the pre-clear data.
- Storage is one dual-port RAM per row (write port A, read port B), inferable as block RAM.

## Timing
- Reset values:
  - o_ready=0, o_valid=0, o_rerr=0, o_werr=0.
  - o_texture_data=0; the output register resets to 0.
  - FSM in CLEAR, cnt=0.
- Asserting rst at any point, including mid-clear or mid-read, aborts all activity. In-flight reads are discarded (no o_valid), and clearing restarts from block 0.
- Clear duration: TEX_COUNT cycles. With rst deasserted before edge 0, o_ready rises after edge TEX_COUNT; default 128.
- Read latency: 2 cycles, fully pipelined.
  - Request accepted at edge N gives o_valid=1 and data during the cycle after edge N+2.
  - One request per cycle is sustained; back-to-back requests give back-to-back valids, in order.
- o_texture_data holds its last value while o_valid=0.
- No backpressure on the read output; the consumer must accept data when o_valid=1.
- Write visibility: a write at edge N is visible to a request accepted at edge N+1.

## Test plan
- Reset then idle: o_ready low for exactly 128 cycles then high. Read of idx 5 returns all zeros, o_valid asserted 2 cycles after the request.
- Write 0xDEADBEEF, strobe 4'hF, to BASE_ADDR+0x100+4*5 (block 1, row 1, lane 1). Read idx 1 -> bits [191:160] = 0xDEADBEEF; all other bits 0.
- Strobe 4'b0101 writing 0x11223344 over 0xAABBCCDD at the same word -> readback 0xAA22CC44.
- Same-cycle write and read of block 2 -> old data returned. A read one cycle later -> new data.
- Write to BASE_ADDR-4 and to BASE_ADDR+128*256 -> o_werr=1, store unchanged. Read idx 200 -> zeros with a one-cycle o_rerr alongside o_valid.
- i_clear after filling block 3, with a read of block 3 in flight -> the in-flight read returns the old data. o_ready stays low 128 cycles, o_werr is cleared, and a later read of block 3 returns zeros. rst pulsed mid-clear -> clearing restarts and takes 128 cycles.
